// File: rtl/tohost_axi_responder_if.sv
// AXI4-Lite style bus bundle for the tohost responder: AW, W, B, AR and R channels.
// Each channel transfers on a rising clock edge where its valid and ready are both high.
interface tohost_axi_responder_if;
    logic [31:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/tohost_axi_responder.sv
// AXI-Lite slave holding the tohost word and a sticky test result (done/pass/fail_num).
// Optional feature: define TOHOST_CYCLE_CNT_EN for a free-running cycle counter at TO_HOST_ADDR + 4.
module tohost_axi_responder #(
    parameter logic [31:0] TO_HOST_ADDR = 32'h0000_3000,
    parameter int          SIM_DELAY    = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    tohost_axi_responder_if.slave       axi,
    output logic                        test_done,
    output logic                        test_pass,
    output logic [30:0]                 fail_num,
    output logic [1:0]                  dbg_w_state,
    output logic                        dbg_r_state
);
    typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [31:0] ADDR_MASK   = 32'hFFFF_FFFC;
    localparam logic [31:0] TOHOST_WORD = TO_HOST_ADDR & ADDR_MASK;
`ifdef TOHOST_CYCLE_CNT_EN
    localparam logic [31:0] CNT_WORD    = (TO_HOST_ADDR + 32'd4) & ADDR_MASK;
`endif

    // Registered outputs carry no delay in this model; a negative value is a setup error.
    if (SIM_DELAY < 0) begin : g_sim_delay_check
        $error("SIM_DELAY must be non-negative");
    end

    w_state_t    w_state_q, w_state_d;
    r_state_t    r_state_q, r_state_d;
    logic [31:0] aw_addr_q, w_data_q;
    logic [3:0]  w_strb_q;
    logic [1:0]  bresp_q, bresp_d;
    logic [31:0] tohost_q;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        aw_fire, w_fire, ar_fire, wr_done;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_strb;
    logic        wr_hit, tohost_we, done_set;
`ifdef TOHOST_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;
`endif

    // Write FSM: next state, channel readies and the merged AW/W view at completion.
    always_comb begin
        w_state_d = w_state_q;
        wr_done   = 1'b0;
        wr_addr   = axi.s_axi_awaddr;
        wr_data   = axi.s_axi_wdata;
        wr_strb   = axi.s_axi_wstrb;
        axi.s_axi_awready = resetn & ((w_state_q == W_IDLE) | (w_state_q == W_WAIT_ADDR));
        axi.s_axi_wready  = resetn & ((w_state_q == W_IDLE) | (w_state_q == W_WAIT_DATA));
        aw_fire = axi.s_axi_awvalid & axi.s_axi_awready;
        w_fire  = axi.s_axi_wvalid & axi.s_axi_wready;
        case (w_state_q)
            W_IDLE: begin
                if (aw_fire && w_fire) begin
                    w_state_d = W_RESP;
                    wr_done   = 1'b1;
                end else if (aw_fire) begin
                    w_state_d = W_WAIT_DATA;
                end else if (w_fire) begin
                    w_state_d = W_WAIT_ADDR;
                end
            end
            W_WAIT_DATA: begin
                wr_addr = aw_addr_q;
                if (w_fire) begin
                    w_state_d = W_RESP;
                    wr_done   = 1'b1;
                end
            end
            W_WAIT_ADDR: begin
                wr_data = w_data_q;
                wr_strb = w_strb_q;
                if (aw_fire) begin
                    w_state_d = W_RESP;
                    wr_done   = 1'b1;
                end
            end
            W_RESP: begin
                if (axi.s_axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write decode: the low two address bits never affect the word selected.
    always_comb begin
        bresp_d = RESP_DECERR;
        wr_hit  = ((wr_addr & ADDR_MASK) == TOHOST_WORD);
        if (wr_hit) begin
            bresp_d = (wr_strb == 4'hF) ? RESP_OKAY : RESP_SLVERR;
        end
`ifdef TOHOST_CYCLE_CNT_EN
        else if ((wr_addr & ADDR_MASK) == CNT_WORD) begin
            bresp_d = RESP_SLVERR;
        end
`endif
        tohost_we = wr_done & wr_hit & (wr_strb == 4'hF);
        done_set  = tohost_we & wr_data[0] & ~test_done;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            tohost_q  <= '0;
            test_done <= 1'b0;
            test_pass <= 1'b0;
            fail_num  <= '0;
        end else begin
            if (w_state_q == W_IDLE && aw_fire && !w_fire) aw_addr_q <= axi.s_axi_awaddr;
            if (w_state_q == W_IDLE && w_fire && !aw_fire) begin
                w_data_q <= axi.s_axi_wdata;
                w_strb_q <= axi.s_axi_wstrb;
            end
            if (wr_done) bresp_q <= bresp_d;
            if (tohost_we) tohost_q <= wr_data;
            if (done_set) begin
                test_done <= 1'b1;
                test_pass <= (wr_data == 32'h1);
                fail_num  <= wr_data[31:1];
            end
        end
    end

`ifdef TOHOST_CYCLE_CNT_EN
    // Counts run time until the result lands, then freezes for readback.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cycle_cnt <= '0;
        end else if (!test_done) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

    // Read FSM and decode; data is captured at the AR handshake so it is stable while rvalid.
    always_comb begin
        r_state_d = r_state_q;
        axi.s_axi_arready = resetn & (r_state_q == R_IDLE);
        ar_fire = axi.s_axi_arvalid & axi.s_axi_arready;
        rdata_d = '0;
        rresp_d = RESP_DECERR;
        if ((axi.s_axi_araddr & ADDR_MASK) == TOHOST_WORD) begin
            rdata_d = tohost_q;
            rresp_d = RESP_OKAY;
        end
`ifdef TOHOST_CYCLE_CNT_EN
        else if ((axi.s_axi_araddr & ADDR_MASK) == CNT_WORD) begin
            rdata_d = cycle_cnt;
            rresp_d = RESP_OKAY;
        end
`endif
        case (r_state_q)
            R_IDLE: if (ar_fire) r_state_d = R_RESP;
            R_RESP: if (axi.s_axi_rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_q <= R_IDLE;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            if (ar_fire) begin
                rdata_q <= rdata_d;
                rresp_q <= rresp_d;
            end
        end
    end

    assign axi.s_axi_bvalid = (w_state_q == W_RESP);
    assign axi.s_axi_bresp  = bresp_q;
    assign axi.s_axi_rvalid = (r_state_q == R_RESP);
    assign axi.s_axi_rdata  = rdata_q;
    assign axi.s_axi_rresp  = rresp_q;
    assign dbg_w_state      = w_state_q;
    assign dbg_r_state      = r_state_q;
endmodule

// File: doc/tohost_axi_responder.md
TOHOST_AXI_RESPONDER -- requirements
Module: tohost_axi_responder

Interface
REQ-001 Parameter TO_HOST_ADDR, default 32'h0000_3000, byte address of the tohost word; bits [1:0] are zero.
REQ-002 Parameter SIM_DELAY, default 1, delay applied to registered outputs in simulation.
REQ-003 Ports: clk  in  1  single clock; all logic on rising edge.
REQ-004 Ports: resetn  in  1  asynchronous, active-low reset.
REQ-005 Ports: s_axi_awaddr in 32, s_axi_awvalid in 1, s_axi_awready out 1  write address channel.
REQ-006 Ports: s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1, s_axi_wready out 1  write data channel.
REQ-007 Ports: s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1  write response channel.
REQ-008 Ports: s_axi_araddr in 32, s_axi_arvalid in 1, s_axi_arready out 1  read address channel.
REQ-009 Ports: s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1  read data channel.
REQ-010 Ports: test_done out 1, test_pass out 1, fail_num out 31  sticky test result.

Function
REQ-011 Write FSM states: W_IDLE, W_WAIT_DATA (AW held), W_WAIT_ADDR (W held), W_RESP.
REQ-012 awready = 1 in W_IDLE and W_WAIT_ADDR only; wready = 1 in W_IDLE and W_WAIT_DATA only; both 0 while resetn low.
REQ-013 W_IDLE: AW+W handshakes same cycle -> W_RESP; AW only -> W_WAIT_DATA (latch awaddr); W only -> W_WAIT_ADDR (latch wdata/wstrb).
REQ-014 W_WAIT_DATA on W handshake, or W_WAIT_ADDR on AW handshake -> W_RESP.
REQ-015 bvalid = 1 exactly in W_RESP, i.e. one cycle after the completing handshake; W_RESP -> W_IDLE on bvalid & bready; bresp stable while bvalid.
REQ-016 Decode at completion: hit = awaddr[31:2] == TO_HOST_ADDR[31:2].
REQ-017 Hit with wstrb = 4'hF: tohost_reg <= wdata, bresp = 2'b00 (OKAY).
REQ-018 Hit with wstrb != 4'hF: no register update, bresp = 2'b10 (SLVERR).
REQ-019 Miss: no effect, bresp = 2'b11 (DECERR).
REQ-020 Full-strobe hit with wdata[0] = 1 and test_done = 0: test_done <= 1, test_pass <= (wdata == 32'h1), fail_num <= wdata[31:1], same edge as bvalid rise.
REQ-021 Result is sticky: once test_done = 1, later writes update tohost_reg only; wdata[0] = 0 never sets test_done.
REQ-022 Read FSM: R_IDLE (arready = 1) -> R_RESP on AR handshake; rvalid = 1 in R_RESP; -> R_IDLE on rvalid & rready; rdata/rresp stable while rvalid.
REQ-023 Read at TO_HOST_ADDR returns tohost_reg, rresp 2'b00; unmapped address returns 32'h0, rresp 2'b11.
REQ-024 Read and write FSMs are independent; a read in the same cycle as a tohost write returns the pre-write value.

Reset
REQ-025 resetn low asynchronously forces W_IDLE, R_IDLE, tohost_reg = 0, bvalid = 0, bresp = 0, rvalid = 0, rdata = 0, rresp = 0, test_done = 0, test_pass = 0, fail_num = 0.
REQ-026 Reset mid-transaction discards any latched AW/W and pending response; no response issued after release.

Configuration
REQ-027 Macro TOHOST_CYCLE_CNT_EN defined: 32-bit cycle_cnt, reset 0, increments each cycle while test_done = 0, freezes when test_done = 1, wraps 32'hFFFF_FFFF -> 0; readable at TO_HOST_ADDR + 4 with OKAY; writes there get SLVERR.
REQ-028 Macro undefined: no counter; TO_HOST_ADDR + 4 decodes as unmapped (DECERR on read and write).

Verification
REQ-029 AW 0x3000 and W 0x0000_0001 strb 4'hF same cycle -> next cycle bvalid = 1, bresp 00, test_done = 1, test_pass = 1, fail_num = 0.
REQ-030 W 0x0000_0007 two cycles before AW 0x3000 -> wready 0 while waiting, bresp 00, test_done = 1, test_pass = 0, fail_num = 3.
REQ-031 AW 0x2000 + W 0x1 -> bresp 11, test_done stays 0; then AW 0x3000 strb 4'h3 -> bresp 10, tohost_reg unchanged.
REQ-032 bready held 0 for 5 cycles after bvalid -> bvalid/bresp held, awready = wready = 0 throughout; second write accepted only after B handshake.
REQ-033 Write 0x15 to 0x3000, then read 0x3000 with rready low 3 cycles -> rdata 0x15, rresp 00 held; second write 0x3 leaves fail_num = 10; with TOHOST_CYCLE_CNT_EN two reads of 0x3004 return equal nonzero values after done.
REQ-034 resetn low while in W_RESP -> bvalid 0, test_done 0 immediately; after release W_IDLE with awready = wready = 1.
